// File: rtl/deser400_merge_arb.sv
// deser400_merge_arb
// Merges the two 16-bit word streams of the dual-channel 400 Mbit
// deserializer (channels A and B) into one tagged valid/ready stream.
// Each channel owns a small circular buffer. A round-robin arbiter picks
// which buffer feeds the single output register. Words that arrive while
// a buffer is full are dropped and counted in a saturating counter.
//
// Ports
//   clk160      in   system clock (160 MHz)
//   reset       in   synchronous, active-high reset
//   run         in   acquisition enable; a rising edge clears ovf_a/ovf_b
//   par_a/b     in   channel word
//   write_a/b   in   single-cycle word strobe
//   dout        out  merged output word
//   dout_ch     out  source channel of dout (0 = A, 1 = B)
//   dout_valid  out  dout/dout_ch valid
//   dout_ready  in   downstream accepts the presented word
//   ovf_a/b     out  saturating dropped-word counters
//   busy        out  registered: a buffer is non-empty or dout_valid is high
module deser400_merge_arb #(
    parameter int DEPTH_LOG2 = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk160,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      par_a,
    input  logic             write_a,
    input  logic [15:0]      par_b,
    input  logic             write_b,
    output logic [15:0]      dout,
    output logic             dout_ch,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] ovf_a,
    output logic [CNT_W-1:0] ovf_b,
    output logic             busy
);

    localparam int D = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef logic [CNT_W-1:0]      ovf_t;

    localparam cnt_t FULL = cnt_t'(D);

    // Index 0 is channel A, index 1 is channel B.
    logic [15:0] mem_q    [2][D];
    ptr_t        wr_ptr_q [2];
    ptr_t        rd_ptr_q [2];
    cnt_t        cnt_q    [2];
    cnt_t        cnt_d    [2];
    ovf_t        ovf_q    [2];

    logic [15:0] dout_q;
    logic        dout_ch_q;
    logic        dout_valid_q;
    logic        dout_valid_d;
    logic        busy_q;
    logic        busy_d;
    logic        run_q;
    logic        last_ch_q;

    logic [15:0] par      [2];
    logic [1:0]  wr;
    logic [1:0]  nonempty;
    logic [1:0]  full;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic [1:0]  drop;
    logic        load;
    logic        any_ne;
    logic        grant;
    logic        run_rise;

    always_comb begin
        par[0]   = par_a;
        par[1]   = par_b;
        wr       = {write_b, write_a};
        run_rise = run & ~run_q;

        for (int c = 0; c < 2; c++) begin
            nonempty[c] = (cnt_q[c] != '0);
            full[c]     = (cnt_q[c] == FULL);
        end

        // The output register can take a new word when it is empty or
        // its current word is being accepted this cycle.
        load   = ~dout_valid_q | dout_ready;
        any_ne = |nonempty;

        // Round robin: with both buffers holding data, serve the channel
        // that was not served last; otherwise serve whichever has data.
        if (&nonempty) begin
            grant = ~last_ch_q;
        end else begin
            grant = ~nonempty[0];
        end

        pop = '0;
        if (load && any_ne) begin
            pop[grant] = 1'b1;
        end

        // A pop in the same cycle frees the slot a full buffer needs.
        for (int c = 0; c < 2; c++) begin
            push[c]  = wr[c] & run & (~full[c] | pop[c]);
            drop[c]  = wr[c] & run & full[c] & ~pop[c];
            cnt_d[c] = cnt_q[c] + cnt_t'(push[c]) - cnt_t'(pop[c]);
        end

        dout_valid_d = load ? any_ne : dout_valid_q;
        busy_d       = (cnt_d[0] != '0) | (cnt_d[1] != '0) | dout_valid_d;
    end

    // Buffer storage carries no reset; the counts define what is valid.
    always_ff @(posedge clk160) begin
        for (int c = 0; c < 2; c++) begin
            if (!reset && push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= par[c];
            end
        end
    end

    always_ff @(posedge clk160) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                ovf_q[c]    <= '0;
            end
            dout_q       <= '0;
            dout_ch_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            run_q        <= 1'b0;
            last_ch_q    <= 1'b1;
        end else begin
            run_q <= run;
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    wr_ptr_q[c] <= wr_ptr_q[c] + ptr_t'(1);
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + ptr_t'(1);
                end
                cnt_q[c] <= cnt_d[c];
                // Start of a run clears the counter; a drop in that same
                // cycle is the first count of the new run.
                if (run_rise) begin
                    ovf_q[c] <= ovf_t'(drop[c]);
                end else if (drop[c] && !(&ovf_q[c])) begin
                    ovf_q[c] <= ovf_q[c] + ovf_t'(1);
                end
            end

            if (load && any_ne) begin
                dout_q    <= mem_q[grant][rd_ptr_q[grant]];
                dout_ch_q <= grant;
                last_ch_q <= grant;
            end
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign ovf_a      = ovf_q[0];
    assign ovf_b      = ovf_q[1];
    assign busy       = busy_q;

endmodule

// File: tb/tb_deser400_merge_arb.sv
// Testbench for deser400_merge_arb: scenario tasks drive the channels and
// push the words they expect to see into a queue; a monitor pops and
// compares every accepted output word and checks that a stalled word holds.
module tb_deser400_merge_arb;

    logic        clk160 = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] par_a;
    logic        write_a;
    logic [15:0] par_b;
    logic        write_b;
    logic [15:0] dout;
    logic        dout_ch;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  ovf_a;
    logic [7:0]  ovf_b;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ch;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        held_v = 1'b0;
    logic [15:0] held_d;
    logic        held_ch;

    always #5 clk160 = ~clk160;

    deser400_merge_arb #(.DEPTH_LOG2(2), .CNT_W(8)) dut (
        .clk160     (clk160),
        .reset      (reset),
        .run        (run),
        .par_a      (par_a),
        .write_a    (write_a),
        .par_b      (par_b),
        .write_b    (write_b),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf_a      (ovf_a),
        .ovf_b      (ovf_b),
        .busy       (busy)
    );

    // Scoreboard monitor: a handshake happens at the next rising edge when
    // valid and ready are both high at the falling edge.
    always @(negedge clk160) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && dout_valid === 1'b1) begin
                checks++;
                if (dout !== held_d || dout_ch !== held_ch) begin
                    errors++;
                    $display("FAIL hold_stable dout=%h ch=%b required dout=%h ch=%b",
                             dout, dout_ch, held_d, held_ch);
                end
            end
            held_v = 1'b0;
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected dout=%h ch=%b required no word", dout, dout_ch);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dout !== mon_e.data || dout_ch !== mon_e.ch) begin
                        errors++;
                        $display("FAIL sb_word dout=%h ch=%b required dout=%h ch=%b",
                                 dout, dout_ch, mon_e.data, mon_e.ch);
                    end
                end
            end else if (dout_valid === 1'b1) begin
                held_v  = 1'b1;
                held_d  = dout;
                held_ch = dout_ch;
            end
        end
    end

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; dout_ready = 1'b0;
        write_a = 1'b0; write_b = 1'b0; par_a = '0; par_b = '0;
        tick(); tick();
        checks++;
        if ({dout, dout_ch, dout_valid, busy} !== 19'd0) begin
            errors++;
            $display("FAIL reset_out dout=%h ch=%b valid=%b busy=%b required all 0",
                     dout, dout_ch, dout_valid, busy);
        end
        checks++;
        if (ovf_a !== 8'd0 || ovf_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_ovf ovf_a=%h ovf_b=%h required 00 00", ovf_a, ovf_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        run = 1'b1; dout_ready = 1'b1;
        tick();
        par_a = 16'h1234; write_a = 1'b1;
        exp_q.push_back('{1'b0, 16'h1234});
        tick();
        write_a = 1'b0;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early valid=%b required 0", dout_valid);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 16'h1234 || dout_ch !== 1'b0) begin
            errors++;
            $display("FAIL single_out valid=%b dout=%h ch=%b required 1 1234 0",
                     dout_valid, dout, dout_ch);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_once valid=%b required 0", dout_valid);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy busy=%b required 0", busy);
        end
    endtask

    task automatic test_pair();
        logic [15:0] words [4];
        words = '{16'hAAA1, 16'hBBB1, 16'hAAA2, 16'hBBB2};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            par_a = words[2*k]; par_b = words[2*k+1];
            write_a = 1'b1; write_b = 1'b1;
            exp_q.push_back('{1'b0, words[2*k]});
            exp_q.push_back('{1'b1, words[2*k+1]});
            tick();
        end
        write_a = 1'b0; write_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== words[k] || dout_ch !== k[0]) begin
                errors++;
                $display("FAIL pair_order k=%0d valid=%b dout=%h ch=%b required 1 %h %b",
                         k, dout_valid, dout, dout_ch, words[k], k[0]);
            end
            tick();
        end
    endtask

    task automatic test_overflow_a();
        dout_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            par_a = 16'(i); write_a = 1'b1;
            if (i <= 5) exp_q.push_back('{1'b0, 16'(i)});
            tick();
        end
        write_a = 1'b0;
        checks++;
        if (ovf_a !== 8'd1 || ovf_b !== 8'd0) begin
            errors++;
            $display("FAIL ovf_a_count ovf_a=%h ovf_b=%h required 01 00", ovf_a, ovf_b);
        end
        tick(); tick(); tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 16'h0001) begin
            errors++;
            $display("FAIL ovf_a_stall valid=%b dout=%h required 1 0001", dout_valid, dout);
        end
    endtask

    task automatic test_full_pass();
        logic [15:0] rest [5];
        rest = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0007};
        dout_ready = 1'b1;
        par_a = 16'h0007; write_a = 1'b1;
        exp_q.push_back('{1'b0, 16'h0007});
        tick();
        write_a = 1'b0;
        checks++;
        if (ovf_a !== 8'd1) begin
            errors++;
            $display("FAIL full_pass_ovf ovf_a=%h required 01", ovf_a);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== rest[k]) begin
                errors++;
                $display("FAIL drain_gap k=%0d valid=%b dout=%h required 1 %h",
                         k, dout_valid, dout, rest[k]);
            end
            tick();
        end
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end valid=%b required 0", dout_valid);
        end
    endtask

    task automatic test_sat_b();
        dout_ready = 1'b0;
        for (int i = 0; i < 310; i++) begin
            par_b = 16'hB000 + 16'(i); write_b = 1'b1;
            if (i < 5) exp_q.push_back('{1'b1, 16'hB000 + 16'(i)});
            tick();
        end
        write_b = 1'b0;
        checks++;
        if (ovf_b !== 8'hFF || ovf_a !== 8'd1) begin
            errors++;
            $display("FAIL sat_b ovf_b=%h ovf_a=%h required ff 01", ovf_b, ovf_a);
        end
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        checks++;
        if (ovf_b !== 8'd0 || ovf_a !== 8'd0) begin
            errors++;
            $display("FAIL run_clear ovf_b=%h ovf_a=%h required 00 00", ovf_b, ovf_a);
        end
    endtask

    task automatic test_rise_drop();
        run = 1'b0;
        tick();
        run = 1'b1; par_b = 16'hBEEF; write_b = 1'b1;
        tick();
        write_b = 1'b0;
        checks++;
        if (ovf_b !== 8'd1) begin
            errors++;
            $display("FAIL rise_drop ovf_b=%h required 01", ovf_b);
        end
    endtask

    task automatic test_run_off();
        int n;
        run = 1'b0;
        par_b = 16'hC000; write_b = 1'b1;
        tick(); tick(); tick();
        write_b = 1'b0;
        checks++;
        if (ovf_b !== 8'd1) begin
            errors++;
            $display("FAIL run_off_count ovf_b=%h required 01", ovf_b);
        end
        dout_ready = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL run_off_drain busy=%b required 0 within 20 cycles", busy);
        end
        par_b = 16'hC001; write_b = 1'b1;
        tick(); tick(); tick();
        write_b = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_off_store valid=%b busy=%b required 0 0", dout_valid, busy);
        end
        run = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            par_a = 16'hA100 + 16'(i); par_b = 16'hB100 + 16'(i);
            write_a = 1'b1; write_b = 1'b1;
            tick();
        end
        write_a = 1'b0; write_b = 1'b0;
        checks++;
        if (ovf_a !== 8'd1 || ovf_b !== 8'd2 || dout_valid !== 1'b1 ||
            dout !== 16'hA100 || dout_ch !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset ovf_a=%h ovf_b=%h valid=%b dout=%h ch=%b required 01 02 1 a100 0",
                     ovf_a, ovf_b, dout_valid, dout, dout_ch);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if ({dout, dout_ch, dout_valid, busy, ovf_a, ovf_b} !== 35'd0) begin
            errors++;
            $display("FAIL mid_reset dout=%h ch=%b valid=%b busy=%b ovf_a=%h ovf_b=%h required all 0",
                     dout, dout_ch, dout_valid, busy, ovf_a, ovf_b);
        end
    endtask

    task automatic test_post_reset();
        dout_ready = 1'b1;
        par_a = 16'hA200; par_b = 16'hB200;
        write_a = 1'b1; write_b = 1'b1;
        exp_q.push_back('{1'b0, 16'hA200});
        exp_q.push_back('{1'b1, 16'hB200});
        tick();
        write_a = 1'b0; write_b = 1'b0;
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout_ch !== 1'b0 || dout !== 16'hA200) begin
            errors++;
            $display("FAIL post_reset_first valid=%b ch=%b dout=%h required 1 0 a200",
                     dout_valid, dout_ch, dout);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout_ch !== 1'b1 || dout !== 16'hB200) begin
            errors++;
            $display("FAIL post_reset_second valid=%b ch=%b dout=%h required 1 1 b200",
                     dout_valid, dout_ch, dout);
        end
        tick(); tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_overflow_a();
        test_full_pass();
        test_sat_b();
        test_rise_drop();
        test_run_off();
        test_reset_mid();
        test_post_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
